// File: rtl/i_memory.sv
// MEM stage: data-memory loads/stores, MEM/WB latch, branch resolve.
// Ports: EX/MEM inputs in; PC_choose/EX_MEM_NPC to IF; MEM_WB_* out.
module i_memory #(
   parameter int ADDR_BITS   = 8,
   parameter int STORE_CNT_W = 16
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [1:0]             wb_ctlin,
   input  logic                   MemRead,
   input  logic                   MemWrite,
   input  logic                   MEM_Branch,
   input  logic                   zero,
   input  logic [31:0]            alu_result,
   input  logic [31:0]            rdata2in,
   input  logic [31:0]            add_result,
   input  logic [4:0]             five_bit_muxin,
   output logic                   PC_choose,
   output logic [31:0]            EX_MEM_NPC,
   output logic [1:0]             MEM_WB_wb,
   output logic [31:0]            MEM_WB_rdata,
   output logic [31:0]            MEM_WB_alu,
   output logic [4:0]             MEM_WB_dst,
   output logic                   mem_fault,
   output logic [STORE_CNT_W-1:0] store_count
);

   localparam int DEPTH = 1 << ADDR_BITS;

   logic [31:0]            r_mem [DEPTH];
   logic [1:0]             r_wb;
   logic [31:0]            r_rdata;
   logic [31:0]            r_alu;
   logic [4:0]             r_dst;
   logic                   r_fault;
   logic [STORE_CNT_W-1:0] r_cnt;

   logic [ADDR_BITS-1:0]   w_idx;
   logic                   w_mis;
   logic                   w_oor;
   logic                   w_fault;
   logic                   w_illegal;
   logic                   w_load;
   logic                   w_store;

   assign PC_choose  = MEM_Branch & zero;
   assign EX_MEM_NPC = add_result;

   assign w_idx     = alu_result[ADDR_BITS+1:2];
   assign w_mis     = |alu_result[1:0];
   assign w_oor     = |alu_result[31:ADDR_BITS+2];
   assign w_fault   = (MemRead | MemWrite) & (w_mis | w_oor);
   assign w_illegal = MemRead & MemWrite;
   assign w_load    = MemRead & ~MemWrite & ~w_fault;
   assign w_store   = MemWrite & ~MemRead & ~w_fault;

   // Array has no reset; writes are held off while reset is asserted.
   always_ff @(posedge clock) begin
      if (w_store && reset_n) begin
         r_mem[w_idx] <= rdata2in;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wb    <= '0;
         r_rdata <= '0;
         r_alu   <= '0;
         r_dst   <= '0;
         r_fault <= 1'b0;
         r_cnt   <= '0;
      end else begin
         // A faulting access must not write back.
         r_wb    <= w_fault ? 2'b00 : wb_ctlin;
         r_rdata <= w_load ? r_mem[w_idx] : 32'd0;
         r_alu   <= alu_result;
         r_dst   <= five_bit_muxin;
         r_fault <= r_fault | w_fault | w_illegal;
         if (w_store && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign MEM_WB_wb    = r_wb;
   assign MEM_WB_rdata = r_rdata;
   assign MEM_WB_alu   = r_alu;
   assign MEM_WB_dst   = r_dst;
   assign mem_fault    = r_fault;
   assign store_count  = r_cnt;

endmodule
